l1a_window_gen: RTL



---
 rtl/l1a_pkg.sv | 15 +
 rtl/l1a_window_gen_if.sv | 43 ++++
 rtl/l1a_wnd_chan.sv | 92 +++++++++
 rtl/l1a_window_gen.sv | 98 +++++++++
 4 files changed

// File: rtl/l1a_pkg.sv
// Shared widths and queue depth for the L1A window generator and its channels.
package l1a_pkg;

    localparam int CNT_W_DEF  = 12;
    localparam int OFS_W_DEF  = 4;
    localparam int BEST_W_DEF = 4;
    localparam int RAW_W_DEF  = 5;
    localparam int QDEPTH_DEF = 4;

    // Width needed to hold a pending count in the range 0..qdepth.
    function automatic int pend_width(input int qdepth);
        return (qdepth < 1) ? 1 : $clog2(qdepth + 1);
    endfunction

endpackage

// File: rtl/l1a_window_gen_if.sv
// Trigger inputs, gating flags and readout-window outputs of l1a_window_gen.
interface l1a_window_gen_if
    import l1a_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int OFS_W  = OFS_W_DEF,
    parameter int BEST_W = BEST_W_DEF,
    parameter int RAW_W  = RAW_W_DEF
);
    logic              l1a_in;
    logic              valor;
    logic              send_empty;
    logic              track;
    logic              l1a_int_en;
    logic              l1a_fifo_full;
    logic              best_full;
    logic              raw_full;
    logic              raw_we_en;
    logic [BEST_W-1:0] best_wnd;
    logic [RAW_W-1:0]  raw_wnd;
    logic [OFS_W-1:0]  l1a_offset;
    logic              l1a_outp;
    logic              best_we;
    logic              raw_we;
    logic              busy;
    logic [CNT_W-1:0]  l1a_in_count;
    logic [CNT_W-1:0]  l1a_acc_count;

    modport master (
        output l1a_in, valor, send_empty, track, l1a_int_en,
               l1a_fifo_full, best_full, raw_full, raw_we_en,
               best_wnd, raw_wnd, l1a_offset,
        input  l1a_outp, best_we, raw_we, busy, l1a_in_count, l1a_acc_count
    );

    modport slave (
        input  l1a_in, valor, send_empty, track, l1a_int_en,
               l1a_fifo_full, best_full, raw_full, raw_we_en,
               best_wnd, raw_wnd, l1a_offset,
        output l1a_outp, best_we, raw_we, busy, l1a_in_count, l1a_acc_count
    );

endinterface

// File: rtl/l1a_wnd_chan.sv
// One readout write-enable window engine: runs a window of latched length per
// request and queues requests that arrive while a window is open.
module l1a_wnd_chan
    import l1a_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [LEN_W-1:0] wnd,
    output logic             we,
    output logic             pend_full
);

    localparam int PEND_W = pend_width(QDEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = LEN_W'(0);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(QDEPTH);

    logic              we_q, we_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PEND_W-1:0] pend_q, pend_d;

    logic              last_s;
    logic              pend_nz_s;
    logic              start_s;
    logic [LEN_W-1:0]  eff_len_s;

    assign eff_len_s = (wnd == LEN_ZERO) ? LEN_ONE : wnd;
    assign last_s    = we_q & (cnt_q >= len_q);
    assign pend_nz_s = (pend_q != PEND_ZERO);
    assign start_s   = (~we_q | last_s) & (pend_nz_s | req);

    // Window and queue next-state; a start on the last cycle chains windows gaplessly.
    always_comb begin
        we_d   = we_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        pend_d = pend_q;
        if (start_s) begin
            we_d  = 1'b1;
            cnt_d = LEN_ONE;
            len_d = eff_len_s;
            if (pend_nz_s) begin
                pend_d = pend_q - PEND_ONE + PEND_W'(req);
            end else begin
                pend_d = pend_q;
            end
        end else begin
            if (we_q && !last_s) begin
                cnt_d = cnt_q + LEN_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (last_s) begin
                we_d = 1'b0;
            end else begin
                we_d = we_q;
            end
            if (req) begin
                pend_d = pend_q + PEND_ONE;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            cnt_q  <= LEN_ZERO;
            len_q  <= LEN_ZERO;
            pend_q <= PEND_ZERO;
        end else begin
            we_q   <= we_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            pend_q <= pend_d;
        end
    end

    // Full flag looks at next-state so the registered busy tracks pend exactly.
    assign pend_full = (pend_d == PEND_MAX);
    assign we        = we_q;

endmodule

// File: rtl/l1a_window_gen.sv
// Accepts external (edge-detected) or internal L1A triggers, counts them, and
// drives queued best-track / raw-hit readout write-enable windows.
module l1a_window_gen
    import l1a_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int OFS_W  = OFS_W_DEF,
    parameter int BEST_W = BEST_W_DEF,
    parameter int RAW_W  = RAW_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    l1a_window_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             l1ar_q, l1ar_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    logic             edge_s;
    logic             accept_s;
    logic             acc_raw_s;
    logic             best_full_s;
    logic             raw_full_s;
    logic             best_we_s;
    logic             raw_we_s;
    logic [CNT_W-1:0] cnt_preset_s;

    assign edge_s    = bus.l1a_in & ~l1ar_q;
    assign accept_s  = reset
                     & (edge_s | (bus.track & bus.l1a_int_en))
                     & ~bus.best_full & ~bus.raw_full & ~bus.l1a_fifo_full
                     & (bus.valor | bus.send_empty)
                     & ~busy_q;
    assign acc_raw_s = accept_s & bus.raw_we_en;

    assign cnt_preset_s = CNT_W'(bus.l1a_offset) - CNT_ONE;

    l1a_wnd_chan #(
        .LEN_W  (BEST_W),
        .QDEPTH (QDEPTH)
    ) u_best_chan (
        .clk       (clk),
        .reset     (reset),
        .req       (accept_s),
        .wnd       (bus.best_wnd),
        .we        (best_we_s),
        .pend_full (best_full_s)
    );

    l1a_wnd_chan #(
        .LEN_W  (RAW_W),
        .QDEPTH (QDEPTH)
    ) u_raw_chan (
        .clk       (clk),
        .reset     (reset),
        .req       (acc_raw_s),
        .wnd       (bus.raw_wnd),
        .we        (raw_we_s),
        .pend_full (raw_full_s)
    );

    // Next-state for edge detector, busy flag and wrapping counters.
    always_comb begin
        l1ar_d    = bus.l1a_in;
        busy_d    = best_full_s | raw_full_s;
        in_cnt_d  = in_cnt_q + CNT_W'(bus.l1a_in);
        acc_cnt_d = acc_cnt_q + CNT_W'(accept_s);
    end

    // Top-level registers; the input counter is preset from the offset during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            l1ar_q    <= 1'b0;
            busy_q    <= 1'b0;
            in_cnt_q  <= cnt_preset_s;
            acc_cnt_q <= CNT_ZERO;
        end else begin
            l1ar_q    <= l1ar_d;
            busy_q    <= busy_d;
            in_cnt_q  <= in_cnt_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign bus.l1a_outp      = accept_s;
    assign bus.best_we       = best_we_s;
    assign bus.raw_we        = raw_we_s;
    assign bus.busy          = busy_q;
    assign bus.l1a_in_count  = in_cnt_q;
    assign bus.l1a_acc_count = acc_cnt_q;

endmodule
